// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding, width helpers and saturating add for matmul_compute
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE} state_e;

  function automatic int cbits(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  function automatic int k_bits(input int maxk);
    return cbits(maxk + 1);
  endfunction

  function automatic int a_addr_bits(input int m, input int maxk);
    return cbits(m * maxk);
  endfunction

  function automatic int b_addr_bits(input int maxk, input int n);
    return cbits(maxk * n);
  endfunction

  // Clamps x+y to the signed range of a w-bit word (w < 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                 input logic signed [63:0] y,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = x + y;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate; MATMUL_ACC_SAT_EN selects sticky saturation over wrap
module mac_unit
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] acc
);

  logic signed [OUTW-1:0] acc_q, acc_d;
  logic signed [63:0]     a64, b64, prod64, sum64;

`ifdef MATMUL_ACC_SAT_EN
  logic sat_q, sat_d;

  // Once a rail is hit the element is pinned there until the next clear.
  always_comb begin
    a64    = 64'(a);
    b64    = 64'(b);
    prod64 = a64 * b64;
    sum64  = sat_add(64'(acc_q), prod64, OUTW);
    acc_d  = acc_q;
    sat_d  = sat_q;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en && !sat_q) begin
      acc_d = OUTW'(sum64);
      sat_d = (sum64 != (64'(acc_q) + prod64));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
`else
  always_comb begin
    a64    = 64'(a);
    b64    = 64'(b);
    prod64 = a64 * b64;
    sum64  = 64'(acc_q) + prod64;
    acc_d  = acc_q;
    if (clear)   acc_d = '0;
    else if (en) acc_d = OUTW'(sum64);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_compute.sv
// rtl/matmul_compute.sv - single-MAC C=A*B compute stage streaming C row-major; option MATMUL_ACC_SAT_EN
module matmul_compute
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int A_ADDR_BITS = a_addr_bits(M, MAXK),
  localparam int B_ADDR_BITS = b_addr_bits(MAXK, N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic signed [INW-1:0]  A_data,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  input  logic signed [INW-1:0]  B_data,
  output logic                   compute_finished,
  output logic signed [OUTW-1:0] AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY
);

  localparam int M_BITS = cbits(M);
  localparam int N_BITS = cbits(N);

  state_e              state_q, state_d;
  logic [M_BITS-1:0]   m_q;
  logic [N_BITS-1:0]   n_q;
  logic [K_BITS-1:0]   k_q, klen_q;
  logic                rvalid_q;
  logic                hs, last_elem, last_k, mac_clear;

  assign hs        = AXIS_TVALID && AXIS_TREADY;
  assign last_elem = (m_q == M_BITS'(M - 1)) && (n_q == N_BITS'(N - 1));
  assign last_k    = (k_q == klen_q - K_BITS'(1));
  // The accumulator is zeroed whenever a new element starts, including K==0 jobs.
  assign mac_clear = ((state_q == IDLE) && matrices_loaded) || ((state_q == OUT) && hs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (matrices_loaded) state_d = (K == '0) ? OUT : ISSUE;
      ISSUE:   if (last_k) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (hs) state_d = last_elem ? DONE : ((klen_q == '0) ? OUT : ISSUE);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    AXIS_TVALID      = (state_q == OUT);
    compute_finished = (state_q == DONE);
    A_read_addr      = '0;
    B_read_addr      = '0;
    if (state_q == ISSUE) begin
      A_read_addr = A_ADDR_BITS'(m_q) * A_ADDR_BITS'(klen_q) + A_ADDR_BITS'(k_q);
      B_read_addr = B_ADDR_BITS'(k_q) * B_ADDR_BITS'(N) + B_ADDR_BITS'(n_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      klen_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (state_q == ISSUE);
      case (state_q)
        IDLE: if (matrices_loaded) begin
          klen_q <= K;
          m_q    <= '0;
          n_q    <= '0;
          k_q    <= '0;
        end
        ISSUE: k_q <= k_q + K_BITS'(1);
        OUT: if (hs) begin
          k_q <= '0;
          if (n_q == N_BITS'(N - 1)) begin
            n_q <= '0;
            m_q <= m_q + M_BITS'(1);
          end else begin
            n_q <= n_q + N_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mac_unit #(.INW(INW), .OUTW(OUTW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .en    (rvalid_q),
    .a     (A_data),
    .b     (B_data),
    .acc   (AXIS_TDATA)
  );

endmodule

// File: tb/tb_matmul_compute.sv
// tb/tb_matmul_compute.sv - randomized model-checked bench for matmul_compute; honours MATMUL_ACC_SAT_EN
module tb_matmul_compute;

  localparam int TM = 3, TN = 4, TMAXK = 8, TINW = 12, TOUTW = 16;
  localparam longint MAXV = (64'sd1 <<< (TOUTW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (TOUTW - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loaded = 1'b0;
  logic [3:0] k_in = '0;
  logic [4:0] a_addr, b_addr;
  logic signed [TINW-1:0] a_data = '0, b_data = '0;
  logic cf, tvalid;
  logic ready = 1'b0;
  logic signed [TOUTW-1:0] tdata;

  logic signed [TINW-1:0] amem [0:TM*TMAXK-1];
  logic signed [TINW-1:0] bmem [0:TMAXK*TN-1];
  int ma [TM][TMAXK];
  int mb [TMAXK][TN];
  longint got_q[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= amem[a_addr];
    b_data <= bmem[b_addr];
  end

  matmul_compute #(.INW(TINW), .OUTW(TOUTW), .M(TM), .N(TN), .MAXK(TMAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (loaded),
    .K                (k_in),
    .A_read_addr      (a_addr),
    .A_data           (a_data),
    .B_read_addr      (b_addr),
    .B_data           (b_data),
    .compute_finished (cf),
    .AXIS_TDATA       (tdata),
    .AXIS_TVALID      (tvalid),
    .AXIS_TREADY      (ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd_elem(input int pat);
    if (pat == 3) return ($urandom_range(0, 1) != 0) ? 2047 : -2048;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // pat 0/3: random, 1: the 2x2 worked example padded with zeros, 2: constants ca/cb
  task automatic set_mats(input int kk, input int pat, input int ca, input int cb);
    for (int i = 0; i < TM; i++)
      for (int k = 0; k < TMAXK; k++)
        ma[i][k] = (pat == 2) ? ca : (pat == 1) ? ((i < 2 && k < 2) ? 2 * i + k + 1 : 0) : rnd_elem(pat);
    for (int k = 0; k < TMAXK; k++)
      for (int j = 0; j < TN; j++)
        mb[k][j] = (pat == 2) ? cb : (pat == 1) ? ((k < 2 && j < 2) ? 2 * k + j + 5 : 0) : rnd_elem(pat);
    for (int i = 0; i < TM * TMAXK; i++) amem[i] = '0;
    for (int i = 0; i < TMAXK * TN; i++) bmem[i] = '0;
    for (int i = 0; i < TM; i++)
      for (int k = 0; k < kk; k++) amem[i * kk + k] = TINW'(ma[i][k]);
    for (int k = 0; k < kk; k++)
      for (int j = 0; j < TN; j++) bmem[k * TN + j] = TINW'(mb[k][j]);
  endtask

  function automatic longint model_elem(input int mm, input int nn, input int kk);
    longint acc, s;
    bit sat;
    acc = 0;
    sat = 0;
    for (int k = 0; k < kk; k++) begin
      s = acc + longint'(ma[mm][k]) * longint'(mb[k][nn]);
`ifdef MATMUL_ACC_SAT_EN
      if (!sat) begin
        if (s > MAXV)      begin acc = MAXV; sat = 1; end
        else if (s < MINV) begin acc = MINV; sat = 1; end
        else acc = s;
      end
`else
      acc = (s <<< (64 - TOUTW)) >>> (64 - TOUTW);
`endif
    end
    return acc;
  endfunction

  // rmode 0: always ready, 1: ready one cycle in three, 2: random ready
  task automatic run_job(input int kk, input int rmode);
    longint exp_q[$];
    int beats, cyc, last_acc, first;
    bit done, addr_ok, prev_stall;
    logic signed [TOUTW-1:0] prev_data;
    beats = 0; cyc = 0; last_acc = -100; first = -1;
    done = 0; addr_ok = 1; prev_stall = 0; prev_data = '0;
    got_q.delete();
    for (int i = 0; i < TM; i++)
      for (int j = 0; j < TN; j++) exp_q.push_back(model_elem(i, j, kk));
    @(negedge clk);
    k_in = 4'(kk);
    loaded = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("stall_valid", longint'(tvalid), 1);
        check("stall_data", longint'(tdata), longint'(prev_data));
      end
      if (kk == 0 && (a_addr != '0 || b_addr != '0)) addr_ok = 0;
      if (cf) begin
        check("done_beats", beats, TM * TN);
        check("done_gap", cyc - last_acc, 1);
        done = 1;
        loaded = 1'b0;
      end else begin
        ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        if (tvalid && first < 0) first = cyc;
        if (tvalid && ready) begin
          if (exp_q.size() > 0) check($sformatf("beat%0d", beats), longint'(tdata), exp_q.pop_front());
          else check("extra_beat", beats + 1, TM * TN);
          got_q.push_back(longint'(tdata));
          beats++;
          last_acc = cyc;
        end
        prev_stall = tvalid && !ready;
        prev_data  = tdata;
      end
    end
    check("job_done", done, 1);
    if (kk > 0) check("latency", first, kk + 2);
    else        check("k0_addr_static", addr_ok, 1);
    @(negedge clk);
    check("done_pulse_width", longint'(cf), 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < TM * TMAXK; i++) amem[i] = '0;
    for (int i = 0; i < TMAXK * TN; i++) bmem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", longint'(tvalid), 0);
    check("rst_tdata", longint'(tdata), 0);
    check("rst_done", longint'(cf), 0);
    check("rst_addr", longint'({a_addr, b_addr}), 0);
    reset = 1'b0;
    @(negedge clk);

    set_mats(2, 1, 0, 0);
    run_job(2, 0);
    check("ex_c00", got_q[0], 19);
    check("ex_c01", got_q[1], 22);
    check("ex_c10", got_q[TN], 43);
    check("ex_c11", got_q[TN + 1], 50);
    run_job(2, 1);
    check("ex_stall_c11", got_q[TN + 1], 50);

    set_mats(1, 2, -2048, -2048);
    run_job(1, 0);
`ifdef MATMUL_ACC_SAT_EN
    check("neg_sq", got_q[0], 32767);
`else
    check("neg_sq", got_q[0], 0);
`endif
    set_mats(1, 2, -1, 5);
    run_job(1, 2);
    check("neg_small", got_q[0], -5);

    set_mats(8, 2, 2047, 2047);
    run_job(8, 0);
`ifdef MATMUL_ACC_SAT_EN
    check("ovf", got_q[0], 32767);
`else
    check("ovf", got_q[0], -32760);
`endif

    set_mats(0, 0, 0, 0);
    run_job(0, 2);
    check("k0_c00", got_q[0], 0);

    // Reset while a result is being offered and stalled.
    set_mats(3, 0, 0, 0);
    @(negedge clk);
    k_in = 4'd3;
    loaded = 1'b1;
    ready = 1'b0;
    w = 0;
    while (!tvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_valid", longint'(tvalid), 1);
    reset = 1'b1;
    #1;
    check("async_rst_tvalid", longint'(tvalid), 0);
    check("async_rst_tdata", longint'(tdata), 0);
    @(negedge clk);
    reset = 1'b0;
    loaded = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_rst", longint'({tvalid, a_addr}), 0);
    set_mats(5, 0, 0, 0);
    run_job(5, 0);

    for (int t = 0; t < 8; t++) begin
      w = int'($urandom_range(1, TMAXK));
      set_mats(w, (t % 3 == 2) ? 3 : 0, 0, 0);
      run_job(w, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
